msk_unmask_out: RTL and testbench

Output-side counterpart of the masked register stage: accepts a fully registered `d`-share sharing of a `count`-bit value and recombines the shares into the unmasked result. The shares are XOR-folded one share per clock from a registered copy, never in a single combinational tree. The block sits at the boundary where masked datapath results (for example a tag or a plaintext block) leave the protected domain, and uses valid/ready handshakes on both sides.

---
 rtl/msk_unmask_pkg.sv | 15 +
 rtl/msk_share_sel.sv | 23 ++
 rtl/msk_unmask_out.sv | 95 +++++++++
 tb/tb_msk_unmask_out.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/msk_unmask_pkg.sv
// Shared definitions for the output-side share recombiner: FSM state encodings and the
// share-counter width helper.
package msk_unmask_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // Share counter needs at least one bit even for a single share.
  function automatic int unsigned cnt_width(input int unsigned d);
    if (d > 1) return int'($clog2(d));
    return 1;
  endfunction

endpackage

// File: rtl/msk_share_sel.sv
// Combinational selector: picks share `cnt` of every bit from the registered share buffer.
module msk_share_sel
  import msk_unmask_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1,
  parameter int unsigned CW    = cnt_width(d)
) (
  input  logic [count*d-1:0] shares,
  input  logic [CW-1:0]      cnt,
  output logic [count-1:0]   share
);

  localparam int D = int'(d);

  always_comb begin
    share = '0;
    for (int i = 0; i < int'(count); i++) begin
      if (int'(cnt) < D) share[i] = shares[i*D + int'(cnt)];
    end
  end

endmodule

// File: rtl/msk_unmask_out.sv
// Recombines a registered d-share sharing into its unmasked value, one share per clock.
// Optional MSK_UNMASK_ZEROIZE_EN clears buffer, accumulator and counter on output handshake.
module msk_unmask_out
  import msk_unmask_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [count*d-1:0] in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [count-1:0]   out_data
);

  localparam int unsigned CW = cnt_width(d);
  localparam logic [CW-1:0] CntLast  = CW'(d - 1);
  localparam logic [CW-1:0] CntFirst = (d > 1) ? CW'(1) : '0;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [count*d-1:0] shares_q, shares_d;
  logic [count-1:0]   acc_q, acc_d;
  logic [count-1:0]   cur_share;

  msk_share_sel #(
    .d     (d),
    .count (count),
    .CW    (CW)
  ) u_share_sel (
    .shares (shares_q),
    .cnt    (cnt_q),
    .share  (cur_share)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shares_d = shares_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shares_d = in;
          for (int i = 0; i < int'(count); i++) acc_d[i] = in[i*int'(d)];
          cnt_d   = CntFirst;
          state_d = (d > 1) ? S_ACC : S_OUT;
        end
      end
      S_ACC: begin
        acc_d = acc_q ^ cur_share;
        // Counter parks at d-1 on the last fold instead of wrapping.
        if (cnt_q == CntLast) begin
          state_d = S_OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
`ifdef MSK_UNMASK_ZEROIZE_EN
          shares_d = '0;
          acc_d    = '0;
          cnt_d    = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shares_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shares_q <= shares_d;
      acc_q    <= acc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  // Output only ever comes from the register; with zeroize the accumulator is 0 in IDLE.
  assign out_data  = acc_q;

endmodule

// File: tb/tb_msk_unmask_out.sv
// Directed, table-driven bench for msk_unmask_out (d=3/count=8 and d=1/count=8 instances).
module tb_msk_unmask_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [23:0] in_bus;
  logic [7:0]  out_data;

  logic        in1_valid, out1_ready;
  logic        in1_ready, out1_valid;
  logic [7:0]  in1_bus;
  logic [7:0]  out1_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msk_unmask_out #(.d(3), .count(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  msk_unmask_out #(.d(1), .count(8)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .in        (in1_bus),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data)
  );

  typedef struct {
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [23:0] pack3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
    logic [23:0] p;
    for (int i = 0; i < 8; i++) begin
      p[i*3]   = a[i];
      p[i*3+1] = b[i];
      p[i*3+2] = c[i];
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready high; checks latency, data and return to IDLE.
  task automatic run_txn(input vec_t v);
    logic [7:0] idle_exp;
    check("pre_in_ready", in_ready, 1);
    in_bus    = pack3(v.s0, v.s1, v.s2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();                       // t0 handshake
    in_valid = 1'b0;
    in_bus   = 24'hFFFFFF;        // later changes must not matter
    check("acc_in_ready", in_ready, 0);
    check("acc_out_valid_t0", out_valid, 0);
    step();                       // t0+1
    check("acc_out_valid_t1", out_valid, 0);
    step();                       // t0+2
    check("out_valid_t2", out_valid, 1);
    check("out_data", out_data, v.exp);
    step();                       // output handshake
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
`ifdef MSK_UNMASK_ZEROIZE_EN
    idle_exp = 8'h00;
`else
    idle_exp = v.exp;
`endif
    check("idle_out_data", out_data, idle_exp);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 8'h96};
    vecs[1] = '{8'h01, 8'h02, 8'h04, 8'h07};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
    vecs[3] = '{8'h80, 8'h01, 8'hFE, 8'h7F};
    vecs[4] = '{8'h10, 8'h20, 8'h40, 8'h70};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_bus     = '0;
    in1_valid  = 1'b0;
    out1_ready = 1'b0;
    in1_bus    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 5; k++) run_txn(vecs[k]);

    // Backpressure: hold out_ready low for 5 cycles in OUT.
    out_ready = 1'b0;
    in_bus    = pack3(8'hA5, 8'h3C, 8'h0F);
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 8'h96);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    check("bp_in_ready_release", in_ready, 0);
    step();
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);

    // Back-to-back with in_valid held high.
    in_bus   = pack3(8'h01, 8'h02, 8'h04);
    in_valid = 1'b1;
    step();                       // t0 first capture
    in_bus = pack3(8'hFF, 8'hFF, 8'h00);
    step();
    step();                       // t0+2 OUT
    check("b2b_out_valid1", out_valid, 1);
    check("b2b_out_data1", out_data, 8'h07);
    step();                       // t0+3 output handshake
    check("b2b_in_ready_gap", in_ready, 1);
    step();                       // t0+4 second capture
    check("b2b_captured", in_ready, 0);
    step();
    step();                       // t0+6 OUT
    in_valid = 1'b0;
    check("b2b_out_valid2", out_valid, 1);
    check("b2b_out_data2", out_data, 8'h00);
    step();
    check("b2b_idle", in_ready, 1);

    // Reset during ACC must act without a clock edge.
    in_bus   = pack3(8'hA5, 8'h3C, 8'h0F);
    in_valid = 1'b1;
    step();                       // capture
    in_valid = 1'b0;
    step();                       // still in ACC
    check("mid_acc_nonzero", (out_data != 8'h00), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_in_ready", in_ready, 1);
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    run_txn(vecs[4]);

    // Single-share instance.
    in1_bus    = 8'h5C;
    in1_valid  = 1'b1;
    out1_ready = 1'b0;
    step();                       // capture
    in1_valid = 1'b0;
    in1_bus   = 8'h00;
    check("d1_out_valid", out1_valid, 1);
    check("d1_out_data", out1_data, 8'h5C);
    check("d1_in_ready", in1_ready, 0);
    out1_ready = 1'b1;
    step();
    check("d1_idle_out_valid", out1_valid, 0);
    check("d1_idle_in_ready", in1_ready, 1);
`ifdef MSK_UNMASK_ZEROIZE_EN
    check("d1_idle_out_data", out1_data, 8'h00);
`else
    check("d1_idle_out_data", out1_data, 8'h5C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
